// File: rtl/ibus_arbiter.sv
// ---------------------------------------------------------------------------
// ibus_arbiter
//
// Purpose:
//   Hands ownership of the shared 4-bit internal bus between up to N
//   tri-state sources (input register, accumulator, ALU, memory read port).
//   The arbiter drives one-hot tri-state enables, so at most one source
//   drives the bus at any time. A dead turnaround of TURN cycles separates
//   two different owners. Selection is round-robin. An owner is forced off
//   the bus after MAXHOLD consecutive cycles if another source is waiting.
//
// Parameters:
//   N        number of requesters / enable outputs (2..8)
//   MAXHOLD  max consecutive grant cycles while another source waits (1..255)
//   TURN     bus-idle cycles between two owners (0..3, 0 = back-to-back)
//
// Optional feature (macro IBUS_PARK_EN):
//   When defined, an idle bus is parked on requester 0 (Enable[0]=1 with
//   GrantValid=0), so the bus is driven by the input register instead of
//   floating. When undefined, an idle bus floats (Enable=0).
//
// Ports:
//   CLK         in   system clock, rising edge
//   Reset       in   synchronous, active-high reset
//   Req[N]      in   per-source level request, bit 0 = input register
//   Enable[N]   out  one-hot (or zero) tri-state enable, bit 0 = EnableIn
//   GrantValid  out  high while a real grant is active
//   GrantIdx[3] out  index of the current owner, 0 when GrantValid=0
//   Busy        out  high while granting or in the turnaround gap
//
// All outputs are registered.
// ---------------------------------------------------------------------------
module ibus_arbiter #(
    parameter int N       = 4,
    parameter int MAXHOLD = 8,
    parameter int TURN    = 1
) (
    input  logic         CLK,
    input  logic         Reset,
    input  logic [N-1:0] Req,
    output logic [N-1:0] Enable,
    output logic         GrantValid,
    output logic [2:0]   GrantIdx,
    output logic         Busy
);

`ifdef IBUS_PARK_EN
    localparam bit PARK_EN = 1'b1;
`else
    localparam bit PARK_EN = 1'b0;
`endif

    localparam logic [7:0] HOLD_MAX  = 8'(MAXHOLD);
    localparam logic [7:0] HOLD_LAST = 8'(MAXHOLD - 1);
    localparam logic [1:0] TURN_LAST = 2'((TURN > 0) ? TURN - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_TURN  = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [2:0]   ptr_q, ptr_d;
    logic [2:0]   owner_q, owner_d;
    logic [7:0]   hold_q, hold_d;
    logic [1:0]   turn_q, turn_d;

    logic [N-1:0] enable_q, enable_d;
    logic         gvalid_q, gvalid_d;
    logic [2:0]   gidx_q, gidx_d;
    logic         busy_q, busy_d;

    // ------------------------------------------------------------------
    // Round-robin winner search
    // ------------------------------------------------------------------
    logic [2:0]     arb_base;
    logic [2*N-1:0] req_dbl;
    logic [N-1:0]   req_rot;
    logic [2:0]     arb_off;
    logic [3:0]     arb_sum;
    logic [2:0]     arb_idx;
    logic           arb_found;

    function automatic logic [2:0] wrap_inc(input logic [2:0] idx);
        if (int'(idx) >= N - 1) begin
            return 3'd0;
        end
        return idx + 3'd1;
    endfunction

    // While an owner is being released, arbitration for a back-to-back
    // handoff must already use the advanced pointer, so the base is derived
    // from the owner instead of the not-yet-updated ptr_q.
    assign arb_base  = (state_q == S_GRANT) ? wrap_inc(owner_q) : ptr_q;
    assign req_dbl   = {Req, Req} >> arb_base;
    assign req_rot   = req_dbl[N-1:0];
    assign arb_found = |Req;

    always_comb begin
        arb_off = 3'd0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                arb_off = 3'(k);
            end
        end
    end

    assign arb_sum = {1'b0, arb_base} + {1'b0, arb_off};
    assign arb_idx = (int'(arb_sum) >= N) ? 3'(int'(arb_sum) - N) : arb_sum[2:0];

    // ------------------------------------------------------------------
    // Owner request decode
    // ------------------------------------------------------------------
    logic [N-1:0] owner_mask;
    logic         own_req;
    logic         oth_req;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_owner_mask
            assign owner_mask[gi] = (owner_q == 3'(gi));
        end
    endgenerate

    assign own_req = |(Req & owner_mask);
    assign oth_req = |(Req & ~owner_mask);

    // Bus is actually parked only in IDLE with the park enable up; right
    // after reset the bus is idle but not yet parked, so no gap is owed.
    logic parked;
    assign parked = PARK_EN && (state_q == S_IDLE) && enable_q[0];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            ptr_q    <= 3'd0;
            owner_q  <= 3'd0;
            hold_q   <= 8'd0;
            turn_q   <= 2'd0;
            enable_q <= '0;
            gvalid_q <= 1'b0;
            gidx_q   <= 3'd0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            hold_q   <= hold_d;
            turn_q   <= turn_d;
            enable_q <= enable_d;
            gvalid_q <= gvalid_d;
            gidx_q   <= gidx_d;
            busy_q   <= busy_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        hold_d  = hold_q;
        turn_d  = turn_q;

        case (state_q)
            S_IDLE: begin
                if (arb_found) begin
                    // Leaving park for a different source still needs the
                    // dead gap, because source 0 was driving the bus.
                    if (parked && (arb_idx != 3'd0) && (TURN > 0)) begin
                        state_d = S_TURN;
                        turn_d  = TURN_LAST;
                    end else begin
                        state_d = S_GRANT;
                        owner_d = arb_idx;
                        hold_d  = 8'd0;
                    end
                end
            end

            S_GRANT: begin
                if (hold_q != HOLD_MAX) begin
                    hold_d = hold_q + 8'd1;
                end
                // Forced release uses >= so that an owner which saturated
                // the counter while alone is still bounded once a competitor
                // shows up.
                if (!own_req || ((hold_q >= HOLD_LAST) && oth_req)) begin
                    ptr_d = wrap_inc(owner_q);
                    if (TURN > 0) begin
                        state_d = S_TURN;
                        turn_d  = TURN_LAST;
                    end else if (arb_found) begin
                        state_d = S_GRANT;
                        owner_d = arb_idx;
                        hold_d  = 8'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end

            S_TURN: begin
                if (turn_q != 2'd0) begin
                    turn_d = turn_q - 2'd1;
                end else if (arb_found) begin
                    state_d = S_GRANT;
                    owner_d = arb_idx;
                    hold_d  = 8'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic (next values of the registered outputs)
    // ------------------------------------------------------------------
    always_comb begin
        gvalid_d = (state_d == S_GRANT);
        gidx_d   = gvalid_d ? owner_d : 3'd0;
        busy_d   = (state_d != S_IDLE);
    end

    generate
        for (gi = 0; gi < N; gi++) begin : g_enable
            if (gi == 0) begin : g_park
                assign enable_d[gi] = (gvalid_d && (owner_d == 3'(gi))) ||
                                      (PARK_EN && (state_d == S_IDLE));
            end else begin : g_plain
                assign enable_d[gi] = gvalid_d && (owner_d == 3'(gi));
            end
        end
    endgenerate

    assign Enable     = enable_q;
    assign GrantValid = gvalid_q;
    assign GrantIdx   = gidx_q;
    assign Busy       = busy_q;

endmodule

// File: tb/tb_ibus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ibus_arbiter
//
// Drives three differently configured arbiters from one shared request
// vector and compares every registered output on every cycle against a
// behavioural model of the bus-ownership rules (owner, cycles held, gap
// remaining, round-robin pointer, park flag).
//
//   inst a: N=4 MAXHOLD=8 TURN=1
//   inst b: N=5 MAXHOLD=3 TURN=0
//   inst c: N=3 MAXHOLD=1 TURN=2
// ---------------------------------------------------------------------------
module tb_ibus_arbiter;

`ifdef IBUS_PARK_EN
    localparam bit PARK = 1'b1;
`else
    localparam bit PARK = 1'b0;
`endif

    localparam int NI = 3;
    localparam int CFG_N    [NI] = '{4, 5, 3};
    localparam int CFG_HOLD [NI] = '{8, 3, 1};
    localparam int CFG_TURN [NI] = '{1, 0, 2};

    logic       clk;
    logic       rst;
    logic [7:0] req_v;

    logic [3:0] en_a;
    logic [4:0] en_b;
    logic [2:0] en_c;
    logic       gv_a, gv_b, gv_c;
    logic [2:0] gi_a, gi_b, gi_c;
    logic       bz_a, bz_b, bz_c;

    int n_checks;
    int n_pass;
    int cyc;

    // behavioural model state, one slot per instance
    int m_owner  [NI];   // -1 = nobody owns the bus
    int m_held   [NI];   // completed cycles of the current grant
    int m_gap    [NI];   // remaining dead cycles before arbitration
    int m_ptr    [NI];   // round-robin start index
    bit m_parked [NI];

    ibus_arbiter #(.N(4), .MAXHOLD(8), .TURN(1)) dut_a (
        .CLK(clk), .Reset(rst), .Req(req_v[3:0]),
        .Enable(en_a), .GrantValid(gv_a), .GrantIdx(gi_a), .Busy(bz_a)
    );

    ibus_arbiter #(.N(5), .MAXHOLD(3), .TURN(0)) dut_b (
        .CLK(clk), .Reset(rst), .Req(req_v[4:0]),
        .Enable(en_b), .GrantValid(gv_b), .GrantIdx(gi_b), .Busy(bz_b)
    );

    ibus_arbiter #(.N(3), .MAXHOLD(1), .TURN(2)) dut_c (
        .CLK(clk), .Reset(rst), .Req(req_v[2:0]),
        .Enable(en_c), .GrantValid(gv_c), .GrantIdx(gi_c), .Busy(bz_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    // Pick the first requester at or after the pointer, cyclically.
    task automatic arbitrate(input int m, input logic [7:0] rq, input bit from_park);
        int w;
        w = -1;
        for (int k = 0; k < CFG_N[m]; k++) begin
            int i;
            i = (m_ptr[m] + k) % CFG_N[m];
            if (w < 0 && rq[i]) w = i;
        end
        if (w < 0) begin
            m_owner[m]  = -1;
            m_parked[m] = PARK;
        end else if (from_park && w != 0 && CFG_TURN[m] > 0) begin
            m_parked[m] = 1'b0;
            m_gap[m]    = CFG_TURN[m];
        end else begin
            m_owner[m]  = w;
            m_held[m]   = 0;
            m_parked[m] = 1'b0;
        end
    endtask

    task automatic model_step(input int m, input logic r, input logic [7:0] q);
        logic [7:0] rq;
        logic [7:0] others;
        rq = q & 8'((1 << CFG_N[m]) - 1);
        if (r) begin
            m_owner[m]  = -1;
            m_held[m]   = 0;
            m_gap[m]    = 0;
            m_ptr[m]    = 0;
            m_parked[m] = 1'b0;
        end else if (m_owner[m] >= 0) begin
            m_held[m]++;
            others = rq & ~(8'd1 << m_owner[m]);
            if (!rq[m_owner[m]] || (m_held[m] >= CFG_HOLD[m] && others != 8'd0)) begin
                m_ptr[m]   = (m_owner[m] + 1) % CFG_N[m];
                m_owner[m] = -1;
                if (CFG_TURN[m] > 0) m_gap[m] = CFG_TURN[m];
                else arbitrate(m, rq, 1'b0);
            end
        end else if (m_gap[m] > 0) begin
            m_gap[m]--;
            if (m_gap[m] == 0) arbitrate(m, rq, 1'b0);
        end else begin
            arbitrate(m, rq, m_parked[m]);
        end
    endtask

    task automatic compare_all();
        for (int m = 0; m < NI; m++) begin
            logic [7:0] o_en;
            logic       o_gv;
            logic [2:0] o_gi;
            logic       o_bz;
            logic [7:0] e_en;
            string      nm;
            case (m)
                0:       begin nm = "a"; o_en = 8'(en_a); o_gv = gv_a; o_gi = gi_a; o_bz = bz_a; end
                1:       begin nm = "b"; o_en = 8'(en_b); o_gv = gv_b; o_gi = gi_b; o_bz = bz_b; end
                default: begin nm = "c"; o_en = 8'(en_c); o_gv = gv_c; o_gi = gi_c; o_bz = bz_c; end
            endcase
            if (m_owner[m] >= 0) e_en = 8'd1 << m_owner[m];
            else                 e_en = m_parked[m] ? 8'd1 : 8'd0;
            chk($sformatf("%s.enable", nm), 32'(o_en), 32'(e_en));
            chk($sformatf("%s.grant_valid", nm), 32'(o_gv), 32'(m_owner[m] >= 0));
            chk($sformatf("%s.grant_idx", nm), 32'(o_gi), (m_owner[m] >= 0) ? 32'(m_owner[m]) : 32'd0);
            chk($sformatf("%s.busy", nm), 32'(o_bz), 32'((m_owner[m] >= 0) || (m_gap[m] > 0)));
        end
    endtask

    // One clock: apply inputs, step the model at the edge, check #1 later.
    task automatic cycle(input logic r, input logic [7:0] q);
        int prev_owner;
        rst   = r;
        req_v = q;
        prev_owner = m_owner[0];
        @(posedge clk);
        cyc++;
        for (int m = 0; m < NI; m++) model_step(m, r, q);
        #1;
        compare_all();
        if (m_owner[0] >= 0 && m_owner[0] != prev_owner)
            $display("cycle %0d: inst a grants owner %0d (req=%b)", cyc, m_owner[0], q[3:0]);
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] cur;
        n_checks = 0;
        n_pass   = 0;
        cyc      = 0;
        for (int m = 0; m < NI; m++) begin
            m_owner[m] = -1; m_held[m] = 0; m_gap[m] = 0; m_ptr[m] = 0; m_parked[m] = 1'b0;
        end
        rst   = 1'b1;
        req_v = 8'h00;
        @(negedge clk);

        // reset held two cycles with every request up, then release
        cycle(1'b1, 8'hFF);
        cycle(1'b1, 8'hFF);
        for (int t = 0; t < 30; t++) cycle(1'b0, 8'hFF);

        // slowly toggling requests with occasional reset pulses
        cur = 8'h00;
        for (int t = 0; t < 1200; t++) begin
            for (int b = 0; b < 5; b++)
                if ($urandom_range(0, 7) == 0) cur[b] = ~cur[b];
            cycle($urandom_range(0, 149) == 0, cur);
        end

        // a single source holds the bus with no competitor
        for (int t = 0; t < 50; t++) cycle(1'b0, 8'h02);
        // a competitor appears after a long solo hold
        for (int t = 0; t < 20; t++) cycle(1'b0, 8'h03);

        // one long-held owner plus a late joiner, then everything idle
        for (int t = 0; t < 3; t++) cycle(1'b0, 8'h04);
        for (int t = 0; t < 20; t++) cycle(1'b0, 8'h05);
        for (int t = 0; t < 10; t++) cycle(1'b0, 8'h00);

        // fast random requests
        for (int t = 0; t < 400; t++) cycle($urandom_range(0, 99) == 0, 8'($urandom));

        // idle tail
        for (int t = 0; t < 10; t++) cycle(1'b0, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
